// File: rtl/emitter_pkg.sv
// Shared types and constants for the overlap-add emitter.
// Window, hop and sample geometry plus the controller state encoding.
package emitter_pkg;

  localparam int ADDR_W  = 12;
  localparam int HOP_W   = 10;
  localparam int DATA_W  = 16;
  localparam int WIN_LEN = 1 << ADDR_W;
  localparam int HOP_LEN = 1 << HOP_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    ACCUM,
    FLUSH,
    DRAIN,
    DONE
  } emit_state_t;

  localparam addr_t LAST_WIN = addr_t'(WIN_LEN - 1);
  localparam addr_t LAST_HOP = addr_t'(HOP_LEN - 1);

  localparam sample_t SAMPLE_MAX = sample_t'(32767);
  localparam sample_t SAMPLE_MIN = sample_t'(-32768);

endpackage

// File: rtl/overlap_emitter_sat_add16.sv
// Saturating signed 16-bit adder used in the accumulate write stage.
// Widens to 17 bits and clamps on overflow instead of wrapping.
module sat_add16
  import emitter_pkg::*;
(
  input  sample_t a,
  input  sample_t b,
  output sample_t y
);

  logic [DATA_W:0] s;

  always_comb begin
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    unique case (s[DATA_W:DATA_W-1])
      2'b01:   y = SAMPLE_MAX;
      2'b10:   y = SAMPLE_MIN;
      default: y = sample_t'(s[DATA_W-1:0]);
    endcase
  end

endmodule

// File: rtl/overlap_emitter.sv
// Overlap-add accumulator controller: sums each stitched window into
// the ring, then streams out and zeroes the completed hop.
module overlap_emitter
  import emitter_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go_in,
  input  logic [1:0]               window_start,
  output logic [ADDR_W-1:0]        in_buf_addr,
  input  logic signed [DATA_W-1:0] in_buf_data,
  output logic [ADDR_W-1:0]        acc_rd_addr,
  input  logic signed [DATA_W-1:0] acc_rd_data,
  output logic [ADDR_W-1:0]        acc_wr_addr,
  output logic signed [DATA_W-1:0] acc_wr_data,
  output logic                     acc_wren,
  output logic signed [DATA_W-1:0] out_sample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  emit_state_t state, next;

  addr_t   idx;
  addr_t   base;
  addr_t   a1;
  logic    v1;
  logic    fresh;
  sample_t hold_q;
  sample_t sum;
  logic    hs;

  assign hs          = out_valid & out_ready;
  assign in_buf_addr = idx;
  assign acc_rd_addr = base + idx;

  // First valid cycle passes RAM data straight through; later cycles hold it.
  assign out_sample = !out_valid ? '0 :
                      fresh      ? acc_rd_data : hold_q;

  sat_add16 u_sat (
    .a (acc_rd_data),
    .b (in_buf_data),
    .y (sum)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      CLEAR: if (idx == LAST_WIN) next = IDLE;
      IDLE:  if (go_in) next = ACCUM;
      ACCUM: if (idx == LAST_WIN) next = FLUSH;
      FLUSH: if (idx == addr_t'(1)) next = DRAIN;
      DRAIN: if (hs && idx == LAST_HOP) next = DONE;
      DONE:  next = IDLE;
      default: next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      base        <= '0;
      a1          <= '0;
      v1          <= 1'b0;
      fresh       <= 1'b0;
      hold_q      <= '0;
      acc_wr_addr <= '0;
      acc_wr_data <= '0;
      acc_wren    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      busy     <= !(next inside {IDLE, DONE});
      done     <= (next == DONE);
      v1       <= (state == ACCUM);
      a1       <= acc_rd_addr;
      fresh    <= 1'b0;
      acc_wren <= 1'b0;
      if (go_in && state != IDLE) overrun <= 1'b1;
      if (fresh) hold_q <= acc_rd_data;
      // Read-modify-write retires two cycles after the address issue.
      if (v1) begin
        acc_wren    <= 1'b1;
        acc_wr_addr <= a1;
        acc_wr_data <= sum;
      end
      unique case (state)
        CLEAR: begin
          acc_wren    <= 1'b1;
          acc_wr_addr <= idx;
          acc_wr_data <= '0;
          idx         <= idx + addr_t'(1);
        end
        IDLE: begin
          if (go_in) begin
            base <= {window_start, {HOP_W{1'b0}}};
            idx  <= '0;
          end
        end
        ACCUM: idx <= idx + addr_t'(1);
        FLUSH: idx <= idx[0] ? '0 : idx + addr_t'(1);
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            fresh     <= 1'b1;
          end else if (out_ready) begin
            out_valid   <= 1'b0;
            acc_wren    <= 1'b1;
            acc_wr_addr <= acc_rd_addr;
            acc_wr_data <= '0;
            idx         <= idx + addr_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_overlap_emitter.sv
// Scoreboard bench for overlap_emitter with behavioural RAMs and an
// array-based overlap-add reference model.
module tb_overlap_emitter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic go_in = 1'b0;
  logic [1:0] window_start = 2'd0;
  logic [11:0] in_buf_addr, acc_rd_addr, acc_wr_addr;
  logic signed [15:0] in_buf_data, acc_rd_data, acc_wr_data, out_sample;
  logic acc_wren, out_valid, busy, done, overrun;
  logic out_ready = 1'b0;

  overlap_emitter dut (
    .clk          (clk),
    .reset        (reset),
    .go_in        (go_in),
    .window_start (window_start),
    .in_buf_addr  (in_buf_addr),
    .in_buf_data  (in_buf_data),
    .acc_rd_addr  (acc_rd_addr),
    .acc_rd_data  (acc_rd_data),
    .acc_wr_addr  (acc_wr_addr),
    .acc_wr_data  (acc_wr_data),
    .acc_wren     (acc_wren),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  logic signed [15:0] sb  [4096];
  logic signed [15:0] ram [4096];
  int wr_cnt [4096];

  // Reset leaves junk in the RAM so the clear pass has to do real work.
  always @(posedge clk) begin
    in_buf_data <= sb[in_buf_addr];
    acc_rd_data <= ram[acc_rd_addr];
    if (reset) begin
      for (int i = 0; i < 4096; i++) begin
        ram[i]    <= 16'sd555;
        wr_cnt[i] <= 0;
      end
    end else if (acc_wren) begin
      ram[acc_wr_addr]    <= acc_wr_data;
      wr_cnt[acc_wr_addr] <= wr_cnt[acc_wr_addr] + 1;
    end
  end

  int ready_pct = 100;
  always @(posedge clk) begin
    #1;
    out_ready = (int'($urandom_range(99)) < ready_pct);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m [4096];
  int q [$];
  int pass_cnt = 0;
  int total = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int first_v = -1;
  int last_out = 0;
  int gc = 0;
  int h0 = 0;
  int d0 = 0;

  task automatic chk(string name, int got, int exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int clamp(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  logic pv = 1'b0;
  logic pr = 1'b0;
  logic signed [15:0] ps = '0;

  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_sample", int'(out_sample), int'(ps));
      end
      if (out_valid && !pv && first_v < 0) first_v = cyc;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_out = int'(out_sample);
        if (q.size() == 0) chk("unexpected_sample", 1, 0);
        else chk("sample", int'(out_sample), q.pop_front());
      end
      pv = out_valid;
      pr = out_ready;
      ps = out_sample;
    end
  end

  task automatic do_reset();
    int bad_val;
    int bad_cnt;
    bad_val = 0;
    bad_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    for (int i = 0; i < 4096; i++) m[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_wren", int'(acc_wren), 0);
    chk("rst_sample", int'(out_sample), 0);
    chk("rst_rd_addr", int'(acc_rd_addr), 0);
    reset = 1'b0;
    repeat (4100) @(negedge clk);
    chk("idle_after_clear", int'(busy), 0);
    for (int i = 0; i < 4096; i++) begin
      if (ram[i] != 16'sd0) bad_val++;
      if (wr_cnt[i] != 1) bad_cnt++;
    end
    chk("clear_values", bad_val, 0);
    chk("clear_once", bad_cnt, 0);
  endtask

  task automatic start_window(int ws, int mode, int val);
    int a;
    for (int i = 0; i < 4096; i++) begin
      if (mode == 0) sb[i] = 16'(val);
      else sb[i] = 16'(int'($urandom_range(65535)) - 32768);
    end
    for (int i = 0; i < 4096; i++) begin
      a = (ws * 1024 + i) % 4096;
      m[a] = clamp(m[a] + int'(sb[i]));
    end
    for (int j = 0; j < 1024; j++) begin
      a = ws * 1024 + j;
      q.push_back(m[a]);
      m[a] = 0;
    end
    @(negedge clk);
    window_start = 2'(ws);
    go_in = 1'b1;
    first_v = -1;
    gc = cyc;
    h0 = hs_cnt;
    d0 = done_cnt;
    @(negedge clk);
    go_in = 1'b0;
  endtask

  task automatic finish_window(int ws, int ovr);
    int n;
    int mism;
    n = 0;
    mism = 0;
    if (ovr == 1) begin
      repeat (40) @(negedge clk);
      chk("busy_accum", int'(busy), 1);
      go_in = 1'b1;
      window_start = 2'(ws + 1);
      @(negedge clk);
      go_in = 1'b0;
      @(negedge clk);
      chk("overrun_accum", int'(overrun), 1);
    end
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
    if (ovr == 2) begin
      go_in = 1'b1;
      window_start = 2'(ws);
      @(negedge clk);
      go_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("no_restart", int'(busy), 0);
      chk("overrun_done", int'(overrun), 1);
    end
    repeat (3) @(negedge clk);
    chk("latency", first_v - gc, 4100);
    chk("handshakes", hs_cnt - h0, 1024);
    chk("done_pulses", done_cnt - d0, 1);
    chk("queue_empty", q.size(), 0);
    for (int i = 0; i < 4096; i++)
      if (int'(ram[i]) != m[i]) mism++;
    chk("acc_ram", mism, 0);
  endtask

  task automatic run_window(int ws, int mode, int val, int ovr);
    start_window(ws, mode, val);
    finish_window(ws, ovr);
  endtask

  initial begin
    int n;
    int ws;
    do_reset();

    run_window(2, 0, 100, 0);
    chk("hop2_value", last_out, 100);
    chk("ram_other", int'(ram[0]), 100);
    chk("ram_hop2_zero", int'(ram[2048]), 0);

    do_reset();
    for (int w = 0; w < 4; w++) run_window(w, 0, 8000, 0);
    chk("fourth_emission", last_out, 32000);
    run_window(0, 0, 16000, 0);
    chk("sat_pos", last_out, 32767);

    ready_pct = 30;
    ws = int'($urandom_range(3));
    run_window(ws, 1, 0, 2);

    ws = int'($urandom_range(3));
    start_window(ws, 1, 0);
    n = 0;
    while (!out_valid && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_reached", int'(out_valid), 1);
    repeat (7) @(negedge clk);
    do_reset();

    ws = int'($urandom_range(3));
    run_window(ws, 1, 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
